// File: rtl/reg_file_param.sv
// reg_file_param: DEPTH x DATA_W register file with two combinational read
// ports, one synchronous write port, optional hardwired zero register,
// optional write-to-read bypass and a one-entry-per-cycle bulk-clear engine.
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic              clear_req,
  output logic              busy,
  output logic              clear_done,
  output logic              dbg_state_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  // IDLE: normal read/write; CLEAR: zeroing entry[ptr] each cycle.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wr_en;
  logic              clr_en;
  logic              wr_zero_reg;

  // A write aimed at the hardwired zero register is silently dropped.
  assign wr_zero_reg = (ZERO_REG != 0) && (write_reg == '0);

  // Next-state logic: writes are only accepted in IDLE; the clear engine
  // walks ptr from 0 to DEPTH-1 and stops there without wrapping.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    clr_en  = 1'b0;
    case (state_q)
      IDLE: begin
        // A write in the same cycle as clear_req still commits; the clear
        // sweep then wipes it.
        wr_en = write_enable && !wr_zero_reg;
        if (clear_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        clr_en = 1'b1;
        if (ptr_q == LAST_PTR) begin
          state_d = IDLE;
          ptr_d   = '0;
          done_d  = 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Control registers; reset overrides everything, including a clear in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
    end
  end

  // Storage array: reset zeroes everything, the clear engine zeroes one entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr_en) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_en) begin
      mem_q[write_reg] <= write_data;
    end
  end

  // Read mux shared by both ports: zero register first, then bypass, then array.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] data;
    data = mem_q[addr];
    if ((BYPASS != 0) && write_enable && (state_q == IDLE) &&
        (write_reg == addr) && !wr_zero_reg) begin
      data = write_data;
    end
    if ((ZERO_REG != 0) && (addr == '0)) begin
      data = '0;
    end
    return data;
  endfunction

  // Combinational read ports, independent of each other.
  always_comb begin
    read_data1 = read_port(read_reg1);
    read_data2 = read_port(read_reg2);
  end

  assign busy        = (state_q == CLEAR);
  assign clear_done  = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: drives two builds of the register file side by side
// (A: ZERO_REG=0 BYPASS=1, B: ZERO_REG=1 BYPASS=0) and compares them every
// cycle against an array-based reference model of the register file.
module tb_reg_file_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        write_enable;
  logic [2:0]  write_reg;
  logic [31:0] write_data;
  logic [2:0]  read_reg1, read_reg2;
  logic        clear_req;

  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic        busy_a, busy_b, done_a, done_b, dbg_a, dbg_b;

  reg_file_param #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .write_enable(write_enable), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(rd1_a), .read_data2(rd2_a), .clear_req(clear_req),
    .busy(busy_a), .clear_done(done_a), .dbg_state_o(dbg_a)
  );

  reg_file_param #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .write_enable(write_enable), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(rd1_b), .read_data2(rd2_b), .clear_req(clear_req),
    .busy(busy_b), .clear_done(done_b), .dbg_state_o(dbg_b)
  );

  // ---------------- reference model ----------------
  // ma/mb hold the architectural contents of build A/B; clear_left counts
  // remaining entries to wipe (0 means idle); done_exp is the pulse expected.
  logic [31:0] ma [8];
  logic [31:0] mb [8];
  int          clear_left;
  logic        done_exp;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
    clear_left = 0;
    done_exp   = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs held over that edge.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (clear_left > 0) begin
      ma[8 - clear_left] = '0;
      mb[8 - clear_left] = '0;
      clear_left--;
      done_exp = (clear_left == 0);
    end else begin
      done_exp = 1'b0;
      if (write_enable) begin
        ma[write_reg] = write_data;
        if (write_reg != 3'd0) mb[write_reg] = write_data;
      end
      if (clear_req) clear_left = 8;
    end
  endtask

  function automatic logic [31:0] exp_read_a(input logic [2:0] addr);
    if (write_enable && clear_left == 0 && write_reg == addr) return write_data;
    return ma[addr];
  endfunction

  function automatic logic [31:0] exp_read_b(input logic [2:0] addr);
    if (addr == 3'd0) return '0;
    return mb[addr];
  endfunction

  // ---------------- driver ----------------
  // Called just after a negedge: drive inputs, check combinational outputs
  // mid-cycle, let the posedge happen, update the model, return at negedge.
  task automatic cycle(input logic we, input logic [2:0] wa, input logic [31:0] wd,
                       input logic [2:0] r1, input logic [2:0] r2,
                       input logic creq, input logic rstn);
    write_enable = we;
    write_reg    = wa;
    write_data   = wd;
    read_reg1    = r1;
    read_reg2    = r2;
    clear_req    = creq;
    rst_n        = rstn;
    #1;
    check("a_rd1", rd1_a, exp_read_a(r1));
    check("a_rd2", rd2_a, exp_read_a(r2));
    check("b_rd1", rd1_b, exp_read_b(r1));
    check("b_rd2", rd2_b, exp_read_b(r2));
    check("a_busy", {31'd0, busy_a}, {31'd0, clear_left > 0});
    check("b_busy", {31'd0, busy_b}, {31'd0, clear_left > 0});
    check("a_done", {31'd0, done_a}, {31'd0, done_exp});
    check("b_done", {31'd0, done_b}, {31'd0, done_exp});
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input logic [2:0] r1, input logic [2:0] r2);
    cycle(1'b0, 3'd0, 32'd0, r1, r2, 1'b0, 1'b1);
  endtask

  task automatic fill_all();
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 3'(i), $urandom, 3'($urandom_range(0, 7)), 3'(i), 1'b0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; write_enable = 1'b0; write_reg = '0; write_data = '0;
    read_reg1 = '0; read_reg2 = '0; clear_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    model_reset();
    @(negedge clk);

    // Reset wipes written contents.
    fill_all();
    cycle(1'b0, 3'd0, 32'd0, 3'd1, 3'd2, 1'b0, 1'b0);
    for (int i = 0; i < 8; i += 2) idle(3'(i), 3'(i + 1));

    // Plain write then read.
    cycle(1'b1, 3'd3, 32'hDEADBEEF, 3'd3, 3'd4, 1'b0, 1'b1);
    idle(3'd3, 3'd4);

    // Bypass on both ports (A forwards, B shows old value until the edge).
    cycle(1'b1, 3'd5, 32'h0000_1234, 3'd5, 3'd5, 1'b0, 1'b1);
    idle(3'd5, 3'd5);

    // Zero register (B ignores the write and never bypasses it).
    cycle(1'b1, 3'd0, 32'hFFFF_FFFF, 3'd0, 3'd0, 1'b0, 1'b1);
    idle(3'd0, 3'd0);

    // Bulk clear with a write in the request cycle and writes while busy.
    fill_all();
    cycle(1'b1, 3'd2, 32'hCAFE_F00D, 3'd2, 3'd7, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 3'($urandom_range(0, 7)), $urandom, 3'(i), 3'(i - 1), 1'b1, 1'b1);
    idle(3'd7, 3'd6);
    idle(3'd1, 3'd2);

    // Reset in the third busy cycle.
    fill_all();
    cycle(1'b0, 3'd0, 32'd0, 3'd0, 3'd1, 1'b1, 1'b1);
    idle(3'd0, 3'd1);
    idle(3'd2, 3'd3);
    cycle(1'b0, 3'd0, 32'd0, 3'd4, 3'd5, 1'b0, 1'b0);
    idle(3'd6, 3'd7);
    idle(3'd0, 3'd5);
    cycle(1'b1, 3'd7, 32'h0000_00A5, 3'd7, 3'd6, 1'b0, 1'b1);
    idle(3'd7, 3'd6);

    // Random traffic: frequent writes, occasional clears, rare resets.
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) != 0));
    end

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
